// File: rtl/alu_mc.sv
// alu_mc: registered ALU with one-cycle arithmetic, logic, compare and shift
// operations. The optional multi-cycle restoring divider is built only when
// the macro ALU_DIV_EN is defined; without it, opcode 0011 completes in one
// cycle and reports Div_Err.
module alu_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALU_FUN,
  input  logic                  En,
  output logic                  Busy,
  output logic [OUT_WIDTH-1:0]  ALU_OUT,
  output logic                  Arith_Flag,
  output logic                  Logic_Flag,
  output logic                  CMP_Flag,
  output logic                  Shift_Flag,
  output logic                  Div_Err,
  output logic                  ALU_Valid
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_EQ   = 4'b1010;
  localparam logic [3:0] OP_GT   = 4'b1011;
  localparam logic [3:0] OP_LT   = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_SHL  = 4'b1110;

  // Result class nibble, ordered {arith, logic, cmp, shift}.
  localparam logic [3:0] CLS_NONE  = 4'b0000;
  localparam logic [3:0] CLS_ARITH = 4'b1000;
  localparam logic [3:0] CLS_LOGIC = 4'b0100;
  localparam logic [3:0] CLS_CMP   = 4'b0010;
  localparam logic [3:0] CLS_SHIFT = 4'b0001;

  // The divider packs quotient and remainder side by side, so the result
  // must be exactly twice the operand width.
  generate
    if (OUT_WIDTH != 2 * DATA_WIDTH) begin : g_bad_out_width
      $error("alu_mc: OUT_WIDTH must equal 2*DATA_WIDTH");
    end
    if (DATA_WIDTH < 4) begin : g_bad_data_width
      $error("alu_mc: DATA_WIDTH must be at least 4");
    end
  endgenerate

  logic [OUT_WIDTH-1:0] a_ext;
  logic [OUT_WIDTH-1:0] b_ext;
  logic [OUT_WIDTH-1:0] op_result;
  logic [3:0]           op_class;
  logic                 op_err;
  logic                 accept;

  logic [OUT_WIDTH-1:0] out_q;
  logic [3:0]           class_q;
  logic                 err_q;
  logic                 valid_q;

  assign a_ext = OUT_WIDTH'(A);
  assign b_ext = OUT_WIDTH'(B);

  // Single-cycle operation decode on zero-extended operands, so the
  // inverting logic ops flip every result bit.
  always_comb begin
    op_result = '0;
    op_class  = CLS_NONE;
    op_err    = 1'b0;
    case (ALU_FUN)
      OP_ADD:  begin op_result = a_ext + b_ext;    op_class = CLS_ARITH; end
      OP_SUB:  begin op_result = a_ext - b_ext;    op_class = CLS_ARITH; end
      OP_MUL:  begin op_result = a_ext * b_ext;    op_class = CLS_ARITH; end
      OP_DIV: begin
        op_class = CLS_ARITH;
        op_err   = 1'b1;
`ifdef ALU_DIV_EN
        op_result = '1;
`else
        op_result = '0;
`endif
      end
      OP_AND:  begin op_result = a_ext & b_ext;    op_class = CLS_LOGIC; end
      OP_OR:   begin op_result = a_ext | b_ext;    op_class = CLS_LOGIC; end
      OP_NAND: begin op_result = ~(a_ext & b_ext); op_class = CLS_LOGIC; end
      OP_NOR:  begin op_result = ~(a_ext | b_ext); op_class = CLS_LOGIC; end
      OP_XOR:  begin op_result = a_ext ^ b_ext;    op_class = CLS_LOGIC; end
      OP_XNOR: begin op_result = ~(a_ext ^ b_ext); op_class = CLS_LOGIC; end
      OP_EQ: begin
        op_result = (A == B) ? OUT_WIDTH'(1) : '0;
        op_class  = CLS_CMP;
      end
      OP_GT: begin
        op_result = (A > B) ? OUT_WIDTH'(2) : '0;
        op_class  = CLS_CMP;
      end
      OP_LT: begin
        op_result = (A < B) ? OUT_WIDTH'(3) : '0;
        op_class  = CLS_CMP;
      end
      OP_SHR:  begin op_result = a_ext >> 1;       op_class = CLS_SHIFT; end
      OP_SHL:  begin op_result = a_ext << 1;       op_class = CLS_SHIFT; end
      default: begin op_result = '0;               op_class = CLS_NONE;  end
    endcase
  end

`ifdef ALU_DIV_EN
  typedef enum logic {
    S_IDLE,
    S_DIV
  } state_t;

  localparam int CNT_W = $clog2(DATA_WIDTH);

  state_t                state;
  state_t                state_next;
  logic                  start_div;
  logic                  div_last;
  logic [CNT_W-1:0]      div_cnt;
  logic [DATA_WIDTH-1:0] div_rem;
  logic [DATA_WIDTH-1:0] div_quo;
  logic [DATA_WIDTH-1:0] div_dvs;
  logic [DATA_WIDTH:0]   div_shift;
  logic [DATA_WIDTH:0]   div_diff;
  logic                  div_bit;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] quo_next;

  // Requests are only taken in IDLE; a zero divisor never enters DIV and is
  // answered in one cycle through the single-cycle path.
  assign accept    = En && (state == S_IDLE);
  assign start_div = accept && (ALU_FUN == OP_DIV) && (B != '0);
  assign div_last  = (state == S_DIV) && (div_cnt == CNT_W'(DATA_WIDTH - 1));
  assign Busy      = (state == S_DIV);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: stay in DIV for DATA_WIDTH iterations, then return.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_div) state_next = S_DIV;
      S_DIV:   if (div_last)  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit and
  // subtract the divisor when it fits.
  always_comb begin
    div_shift = {div_rem, div_quo[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, div_dvs};
    div_bit   = 1'b0;
    rem_next  = div_shift[DATA_WIDTH-1:0];
    if (div_shift >= {1'b0, div_dvs}) begin
      div_bit  = 1'b1;
      rem_next = div_diff[DATA_WIDTH-1:0];
    end
    quo_next = {div_quo[DATA_WIDTH-2:0], div_bit};
  end

  // Divider working registers: loaded on accept, stepped once per DIV cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt <= '0;
      div_rem <= '0;
      div_quo <= '0;
      div_dvs <= '0;
    end else if (start_div) begin
      div_cnt <= '0;
      div_rem <= '0;
      div_quo <= A;
      div_dvs <= B;
    end else if (state == S_DIV) begin
      div_cnt <= div_cnt + 1'b1;
      div_rem <= rem_next;
      div_quo <= quo_next;
    end
  end

  // Result register: the final divide step writes {remainder, quotient};
  // every other accepted request is registered on its accepting edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q   <= '0;
      class_q <= CLS_NONE;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (div_last) begin
        out_q   <= {rem_next, quo_next};
        class_q <= CLS_ARITH;
        err_q   <= 1'b0;
        valid_q <= 1'b1;
      end else if (accept && !start_div) begin
        out_q   <= op_result;
        class_q <= op_class;
        err_q   <= op_err;
        valid_q <= 1'b1;
      end
    end
  end
`else
  assign accept = En;
  assign Busy   = 1'b0;

  // Result register: every request completes on its accepting edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q   <= '0;
      class_q <= CLS_NONE;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        out_q   <= op_result;
        class_q <= op_class;
        err_q   <= op_err;
        valid_q <= 1'b1;
      end
    end
  end
`endif

  assign ALU_OUT    = out_q;
  assign Arith_Flag = class_q[3];
  assign Logic_Flag = class_q[2];
  assign CMP_Flag   = class_q[1];
  assign Shift_Flag = class_q[0];
  assign Div_Err    = err_q;
  assign ALU_Valid  = valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc at DATA_WIDTH=8. Expected results
// are queued when a request is driven and popped when ALU_Valid pulses.
// Divide expectations follow whether ALU_DIV_EN is defined.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  alu_fun;
  logic        en;
  logic        busy;
  logic [15:0] alu_out;
  logic        arith_flag;
  logic        logic_flag;
  logic        cmp_flag;
  logic        shift_flag;
  logic        div_err;
  logic        alu_valid;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  cls;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   check_count = 0;
  int   pass_count  = 0;
  int   cyc         = 0;
  int   busy_cnt    = 0;

`ifdef ALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_mc #(.DATA_WIDTH(8), .OUT_WIDTH(16)) dut (
    .CLK        (clk),
    .RST        (rst),
    .A          (a),
    .B          (b),
    .ALU_FUN    (alu_fun),
    .En         (en),
    .Busy       (busy),
    .ALU_OUT    (alu_out),
    .Arith_Flag (arith_flag),
    .Logic_Flag (logic_flag),
    .CMP_Flag   (cmp_flag),
    .Shift_Flag (shift_flag),
    .Div_Err    (div_err),
    .ALU_Valid  (alu_valid)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Reference model of one request, written from the opcode table.
  task automatic modelAlu(input logic [7:0] ma, input logic [7:0] mb, input logic [3:0] mf,
                          output logic [15:0] res, output logic [3:0] cls,
                          output logic err, output int lat);
    int ai, bi, r;
    ai  = int'(ma);
    bi  = int'(mb);
    r   = 0;
    err = 1'b0;
    lat = 1;
    case (mf)
      4'd0:  r = ai + bi;
      4'd1:  r = ai - bi;
      4'd2:  r = ai * bi;
      4'd3: begin
        if (!DIV_ON) begin
          r = 0; err = 1'b1;
        end else if (bi == 0) begin
          r = 'hFFFF; err = 1'b1;
        end else begin
          r = ((ai % bi) << 8) | (ai / bi); lat = 9;
        end
      end
      4'd4:  r = ai & bi;
      4'd5:  r = ai | bi;
      4'd6:  r = ~(ai & bi);
      4'd7:  r = ~(ai | bi);
      4'd8:  r = ai ^ bi;
      4'd9:  r = ~(ai ^ bi);
      4'd10: r = (ai == bi) ? 1 : 0;
      4'd11: r = (ai > bi) ? 2 : 0;
      4'd12: r = (ai < bi) ? 3 : 0;
      4'd13: r = ai >> 1;
      4'd14: r = ai << 1;
      default: r = 0;
    endcase
    res = r[15:0];
    if (mf <= 4'd3)       cls = 4'b1000;
    else if (mf <= 4'd9)  cls = 4'b0100;
    else if (mf <= 4'd12) cls = 4'b0010;
    else if (mf <= 4'd14) cls = 4'b0001;
    else                  cls = 4'b0000;
  endtask

  // Drive one request at a falling edge and queue what it must produce.
  task automatic applyStimulus(input logic [7:0] sa, input logic [7:0] sb, input logic [3:0] sf,
                               input logic [15:0] res, input logic [3:0] cls,
                               input logic err, input int lat);
    exp_t e;
    a       = sa;
    b       = sb;
    alu_fun = sf;
    en      = 1'b1;
    e.res   = res;
    e.cls   = cls;
    e.err   = err;
    e.due   = cyc + lat;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic applyModel(input logic [7:0] sa, input logic [7:0] sb, input logic [3:0] sf);
    logic [15:0] res;
    logic [3:0]  cls;
    logic        err;
    int          lat;
    modelAlu(sa, sb, sf, res, cls, err, lat);
    applyStimulus(sa, sb, sf, res, cls, err, lat);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 60 && sb_q.size() > 0; i++) @(negedge clk);
    checkOutput({tag, "_drain"}, sb_q.size(), 0);
  endtask

  // Monitor: count Busy cycles and compare every result pulse to the queue.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (alu_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("alu_out", alu_out, mon_e.res);
        checkOutput("flags", {arith_flag, logic_flag, cmp_flag, shift_flag}, mon_e.cls);
        checkOutput("div_err", div_err, mon_e.err);
        checkOutput("latency", cyc, mon_e.due);
      end
    end
  end

  int exp_tab[16] = '{18, 12, 45, 0, 3, 15, 'hFFFC, 'hFFF0, 12, 'hFFF3, 0, 2, 0, 7, 30, 0};
  int cls_tab[16] = '{8, 8, 8, 8, 4, 4, 4, 4, 4, 4, 2, 2, 2, 1, 1, 0};

  initial begin
    rst = 1'b1; en = 1'b0; a = '0; b = '0; alu_fun = '0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out", alu_out, 0);
    checkOutput("rst_flags", {arith_flag, logic_flag, cmp_flag, shift_flag}, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", alu_valid, 0);
    checkOutput("rst_err", div_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Every single-cycle opcode back to back with A=15, B=3.
    for (int f = 0; f < 16; f++) begin
      if (f != 3)
        applyStimulus(8'd15, 8'd3, 4'(f), 16'(exp_tab[f]), 4'(cls_tab[f]), 1'b0, 1);
    end
    en = 1'b0;
    waitDrain("ops");

    // 200/7 = 28 remainder 4.
    busy_cnt = 0;
    if (DIV_ON) applyStimulus(8'd200, 8'd7, 4'd3, 16'h041C, 4'b1000, 1'b0, 9);
    else        applyStimulus(8'd200, 8'd7, 4'd3, 16'h0000, 4'b1000, 1'b1, 1);
    en = 1'b0;
    waitDrain("div");
    checkOutput("div_busy_cycles", busy_cnt, DIV_ON ? 8 : 0);

    // Divide by zero, then an ADD that clears the error.
    busy_cnt = 0;
    applyStimulus(8'd9, 8'd0, 4'd3, DIV_ON ? 16'hFFFF : 16'h0000, 4'b1000, 1'b1, 1);
    applyModel(8'd1, 8'd2, 4'd0);
    en = 1'b0;
    waitDrain("div0");
    checkOutput("div0_busy", busy_cnt, 0);

    // An ADD two cycles into a divide must be dropped.
    busy_cnt = 0;
    applyModel(8'd100, 8'd9, 4'd3);
    en = 1'b0;
    @(negedge clk);
    a = 8'd5; b = 8'd5; alu_fun = 4'd0; en = DIV_ON;
    @(negedge clk);
    en = 1'b0;
    waitDrain("div_ignore");
    checkOutput("ignore_busy_cycles", busy_cnt, DIV_ON ? 8 : 0);
    repeat (3) @(negedge clk);

    // Reset during the fourth divide cycle aborts it silently.
    applyModel(8'd50, 8'd3, 4'd3);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_out", alu_out, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", alu_valid, 0);
    checkOutput("abort_flags", {arith_flag, logic_flag, cmp_flag, shift_flag}, 0);
    repeat (12) @(negedge clk);
    applyStimulus(8'd1, 8'd1, 4'd0, 16'd2, 4'b1000, 1'b0, 1);
    en = 1'b0;
    waitDrain("post_abort");

    // Random single-cycle operations, including operand extremes.
    for (int i = 0; i < 24; i++) begin
      logic [3:0] rf;
      rf = 4'($urandom_range(0, 15));
      if (rf == 4'd3) rf = 4'd14;
      if (i < 4) applyModel((i % 2 == 0) ? 8'hFF : 8'h00, (i < 2) ? 8'hFF : 8'h01, 4'(6 + i));
      else       applyModel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rf);
    end
    en = 1'b0;
    waitDrain("random");

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width (min 4).
REQ-002 SHALL have parameter OUT_WIDTH, default 2*DATA_WIDTH, result width; any other value is illegal.
REQ-003 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports A, B  in  DATA_WIDTH  unsigned operands, sampled on accept.
REQ-006 SHALL have port ALU_FUN  in  4  opcode, sampled on accept.
REQ-007 SHALL have port En  in  1  operation request.
REQ-008 SHALL have port Busy  out  1  multi-cycle operation in progress.
REQ-009 SHALL have port ALU_OUT  out  OUT_WIDTH  registered result.
REQ-010 SHALL have ports Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  out  1 each  class of the current result, one-hot or all zero.
REQ-011 SHALL have port Div_Err  out  1  divide-by-zero or divide not supported.
REQ-012 SHALL have port ALU_Valid  out  1  one-cycle pulse: result present.

Function
REQ-013 SHALL accept a request on a rising edge with En=1 and state IDLE; En with state DIV is ignored, and the operands it carries are dropped.
REQ-014 SHALL decode ALU_FUN as follows:
- 0000 ADD
- 0001 SUB, two's complement, wraps mod 2^OUT_WIDTH
- 0010 MUL, full width
- 0011 DIV
- 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR
- 1010 EQ, 1011 GT, 1100 LT
- 1101 SHR A by 1, 1110 SHL A by 1
- 1111 NOP
REQ-015 SHALL zero-extend A and B to OUT_WIDTH before every operation, so NAND/NOR/XNOR invert across all OUT_WIDTH bits.
REQ-016 SHALL return 1 for EQ true, 2 for GT true and 3 for LT true, and 0 when the compare is false.
REQ-017 SHALL return 0 for NOP with all flags 0, ALU_Valid=1.
REQ-018 SHALL register every non-DIV result on the accepting edge: latency 1, ALU_Valid=1 for exactly that cycle.
REQ-019 SHALL set exactly one class flag with each result (ADD/SUB/MUL/DIV Arith; 0100-1001 Logic; 1010-1100 CMP; 1101-1110 Shift); ALU_OUT and flags hold until the next result.
REQ-020 SHALL implement the state machine IDLE->DIV on accept of DIV with B!=0, remaining in DIV for DATA_WIDTH cycles of restoring division, then DIV->IDLE.
REQ-021 SHALL, for DIV, assert Busy from the accepting edge until the result edge, with ALU_Valid on edge DATA_WIDTH+1 after accept.
REQ-022 SHALL place the DIV quotient in ALU_OUT[DATA_WIDTH-1:0] and the remainder in ALU_OUT[OUT_WIDTH-1:DATA_WIDTH].
REQ-023 SHALL, for DIV with B=0, take no DIV state and instead set latency 1, ALU_OUT all ones, Div_Err=1, Arith_Flag=1, ALU_Valid=1.
REQ-024 SHALL deassert Busy on the result edge so that a new En is accepted on the next edge, giving back-to-back throughput.
REQ-025 SHALL clear Div_Err on the next accepted result without error.

Reset
REQ-026 SHALL, on RST=1 at a rising edge, drive ALU_OUT=0, all flags 0, Div_Err=0, ALU_Valid=0, Busy=0 and state IDLE.
REQ-027 SHALL abort a divide in progress when RST is asserted mid-DIV, emitting no ALU_Valid; RST takes priority over En.

Configuration
REQ-028 SHALL, with macro ALU_DIV_EN defined, include the sequential divider per REQ-020..023.
REQ-029 SHALL, without ALU_DIV_EN, omit the divider and DIV state; opcode 0011 then completes in 1 cycle with ALU_OUT=0, Div_Err=1, Arith_Flag=1, ALU_Valid=1, and Busy is constant 0.

Verification (DATA_WIDTH=8, ALU_DIV_EN defined)
REQ-030 SHALL cover: RST=1 for 2 cycles -> ALU_OUT=0, all flags 0, Busy=0, ALU_Valid=0.
REQ-031 SHALL cover: A=15, B=3, ALU_FUN 0000..1111 issued one per cycle (except 0011) -> respectively 18, 12, 45, 3, 15, 0xFFFC, 0xFFF0, 12, 0xFFF3, 0, 2, 0, 7 (SHR), 30 (SHL), 0 with the correct flag, each Valid one cycle after En.
REQ-032 SHALL cover: A=200, B=7, DIV -> Busy=1 for 8 cycles, then ALU_Valid=1, ALU_OUT=0x041C, Arith_Flag=1, Div_Err=0.
REQ-033 SHALL cover: A=9, B=0, DIV -> next edge ALU_OUT=0xFFFF, Div_Err=1, Busy never 1.
REQ-034 SHALL cover: En=1 with ADD 2 cycles into a divide -> ignored, single ALU_Valid carrying only the divide result.
REQ-035 SHALL cover: RST=1 at the 4th DIV cycle -> no ALU_Valid, outputs 0; subsequent ADD 1+1 -> ALU_OUT=2 one edge later.
